// File: rtl/aib_cfg_pkg.sv
// Shared constants, request payload, FSM states and byte-enable merge
// for the AIB AVMM configuration register slave.
package aib_cfg_pkg;

  localparam int unsigned CFG_ADDR_W = 17;
  localparam int unsigned CFG_DATA_W = 32;
  localparam int unsigned CFG_BE_W   = 4;
  localparam int unsigned CFG_OFF_CMP_W = 16;

  localparam logic [CFG_OFF_CMP_W-1:0] CFG_CHNL_ID  = 16'h0200;
  localparam logic [CFG_OFF_CMP_W-1:0] CFG_RX_ADAPT = 16'h0208;
  localparam logic [CFG_OFF_CMP_W-1:0] CFG_TX_ADAPT = 16'h0210;
  localparam logic [CFG_OFF_CMP_W-1:0] CFG_AIB_CSR0 = 16'h0218;
  localparam logic [CFG_OFF_CMP_W-1:0] CFG_AIB_CSR1 = 16'h021C;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    RESP
  } cfg_state_e;

  // Latched copy of one host request; rd is already cleared when wr is set.
  typedef struct packed {
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] wdata;
    logic [CFG_BE_W-1:0]   be;
    logic                  wr;
    logic                  rd;
  } cfg_req_t;

  function automatic logic [CFG_DATA_W-1:0] be_merge(
    input logic [CFG_DATA_W-1:0] old,
    input logic [CFG_DATA_W-1:0] wdata,
    input logic [CFG_BE_W-1:0]   be
  );
    logic [CFG_DATA_W-1:0] res;
    res = old;
    for (int unsigned k = 0; k < CFG_BE_W; k++) begin
      if (be[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aib_cfg_chnl_regs.sv
// Four configuration registers for one channel plus the combinational
// read mux for that channel's offsets.
module aib_cfg_chnl_regs
  import aib_cfg_pkg::*;
#(
  parameter int unsigned OFF_W    = 11,
  parameter int unsigned CHNL_IDX = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [OFF_W-1:0]      offset_i,
  input  logic [CFG_DATA_W-1:0] wdata_i,
  input  logic [CFG_BE_W-1:0]   be_i,
  output logic [CFG_DATA_W-1:0] rd_data_c_o,
  output logic [CFG_DATA_W-1:0] rx_adapt_o,
  output logic [CFG_DATA_W-1:0] tx_adapt_o,
  output logic [CFG_DATA_W-1:0] aib_csr0_o,
  output logic [CFG_DATA_W-1:0] aib_csr1_o
);

  logic [CFG_OFF_CMP_W-1:0] off_c;
  logic [CFG_DATA_W-1:0]    rx_q, rx_d;
  logic [CFG_DATA_W-1:0]    tx_q, tx_d;
  logic [CFG_DATA_W-1:0]    csr0_q, csr0_d;
  logic [CFG_DATA_W-1:0]    csr1_q, csr1_d;

  assign off_c = CFG_OFF_CMP_W'(offset_i);

  // Byte-enable merge into whichever register the offset selects.
  always_comb begin
    rx_d   = rx_q;
    tx_d   = tx_q;
    csr0_d = csr0_q;
    csr1_d = csr1_q;
    if (wr_en_i) begin
      case (off_c)
        CFG_RX_ADAPT: rx_d   = be_merge(rx_q, wdata_i, be_i);
        CFG_TX_ADAPT: tx_d   = be_merge(tx_q, wdata_i, be_i);
        CFG_AIB_CSR0: csr0_d = be_merge(csr0_q, wdata_i, be_i);
        CFG_AIB_CSR1: csr1_d = be_merge(csr1_q, wdata_i, be_i);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_q   <= '0;
      tx_q   <= '0;
      csr0_q <= '0;
      csr1_q <= '0;
    end else begin
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      csr0_q <= csr0_d;
      csr1_q <= csr1_d;
    end
  end

  // Unmapped offsets read as zero; the ID word is hard-wired.
  always_comb begin
    rd_data_c_o = '0;
    case (off_c)
      CFG_CHNL_ID:  rd_data_c_o = {26'b0, 6'(CHNL_IDX)};
      CFG_RX_ADAPT: rd_data_c_o = rx_q;
      CFG_TX_ADAPT: rd_data_c_o = tx_q;
      CFG_AIB_CSR0: rd_data_c_o = csr0_q;
      CFG_AIB_CSR1: rd_data_c_o = csr1_q;
      default: ;
    endcase
  end

  assign rx_adapt_o = rx_q;
  assign tx_adapt_o = tx_q;
  assign aib_csr0_o = csr0_q;
  assign aib_csr1_o = csr1_q;

endmodule

// File: rtl/aib_avmm_cfg_regs.sv
// AVMM configuration slave: handshake FSM, channel decode and the
// per-channel register banks driven out as flattened buses.
module aib_avmm_cfg_regs
  import aib_cfg_pkg::*;
#(
  parameter int unsigned CHNL_NUM    = 24,
  parameter int unsigned CHNL_ID_LSB = 11
) (
  input  logic                           i_cfg_avmm_clk,
  input  logic                           i_cfg_avmm_rst_n,
  input  logic [CFG_ADDR_W-1:0]          i_cfg_avmm_addr,
  input  logic                           i_cfg_avmm_write,
  input  logic                           i_cfg_avmm_read,
  input  logic [CFG_BE_W-1:0]            i_cfg_avmm_byte_en,
  input  logic [CFG_DATA_W-1:0]          i_cfg_avmm_wdata,
  output logic [CFG_DATA_W-1:0]          o_cfg_avmm_rdata,
  output logic                           o_cfg_avmm_rdatavld,
  output logic                           o_cfg_avmm_waitreq,
  output logic [CFG_DATA_W*CHNL_NUM-1:0] o_rx_adapt_cfg,
  output logic [CFG_DATA_W*CHNL_NUM-1:0] o_tx_adapt_cfg,
  output logic [CFG_DATA_W*CHNL_NUM-1:0] o_aib_csr0,
  output logic [CFG_DATA_W*CHNL_NUM-1:0] o_aib_csr1
);

  localparam int unsigned IDX_W = CFG_ADDR_W - CHNL_ID_LSB;

  cfg_state_e            state_q, state_d;
  cfg_req_t              req_q, req_d;
  logic [CFG_DATA_W-1:0] rdata_q, rdata_d;
  logic                  rdatavld_q, rdatavld_d;
  logic                  waitreq_q, waitreq_d;
  logic                  wr_commit_c;
  logic [IDX_W-1:0]      chnl_idx_c;
  logic [CHNL_ID_LSB-1:0] offset_c;
  logic [CFG_DATA_W-1:0] rd_mux_c;
  logic [CFG_DATA_W-1:0] chnl_rdata_c [CHNL_NUM];

  assign chnl_idx_c = req_q.addr[CFG_ADDR_W-1:CHNL_ID_LSB];
  assign offset_c   = req_q.addr[CHNL_ID_LSB-1:0];

  // Indices at or above CHNL_NUM match no bank and so read as zero.
  always_comb begin
    rd_mux_c = '0;
    for (int unsigned n = 0; n < CHNL_NUM; n++) begin
      if (chnl_idx_c == IDX_W'(n)) rd_mux_c = chnl_rdata_c[n];
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rdata_d     = '0;
    rdatavld_d  = 1'b0;
    waitreq_d   = 1'b1;
    wr_commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_cfg_avmm_write || i_cfg_avmm_read) begin
          req_d.addr  = i_cfg_avmm_addr;
          req_d.wdata = i_cfg_avmm_wdata;
          req_d.be    = i_cfg_avmm_byte_en;
          req_d.wr    = i_cfg_avmm_write;
          req_d.rd    = i_cfg_avmm_read && !i_cfg_avmm_write;
          waitreq_d   = 1'b0;
          state_d     = ACCEPT;
        end
      end
      ACCEPT: begin
        wr_commit_c = req_q.wr;
        if (req_q.rd) begin
          rdata_d    = rd_mux_c;
          rdatavld_d = 1'b1;
          state_d    = RESP;
        end else begin
          state_d = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) begin
      state_q    <= IDLE;
      req_q      <= '0;
      rdata_q    <= '0;
      rdatavld_q <= 1'b0;
      waitreq_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rdata_q    <= rdata_d;
      rdatavld_q <= rdatavld_d;
      waitreq_q  <= waitreq_d;
    end
  end

  assign o_cfg_avmm_rdata    = rdata_q;
  assign o_cfg_avmm_rdatavld = rdatavld_q;
  assign o_cfg_avmm_waitreq  = waitreq_q;

  for (genvar n = 0; n < CHNL_NUM; n++) begin : g_chnl
    aib_cfg_chnl_regs #(
      .OFF_W    (CHNL_ID_LSB),
      .CHNL_IDX (n)
    ) u_chnl_regs (
      .clk_i       (i_cfg_avmm_clk),
      .rst_n_i     (i_cfg_avmm_rst_n),
      .wr_en_i     (wr_commit_c && (chnl_idx_c == IDX_W'(n))),
      .offset_i    (offset_c),
      .wdata_i     (req_q.wdata),
      .be_i        (req_q.be),
      .rd_data_c_o (chnl_rdata_c[n]),
      .rx_adapt_o  (o_rx_adapt_cfg[CFG_DATA_W*n +: CFG_DATA_W]),
      .tx_adapt_o  (o_tx_adapt_cfg[CFG_DATA_W*n +: CFG_DATA_W]),
      .aib_csr0_o  (o_aib_csr0[CFG_DATA_W*n +: CFG_DATA_W]),
      .aib_csr1_o  (o_aib_csr1[CFG_DATA_W*n +: CFG_DATA_W])
    );
  end

endmodule

// File: tb/tb_aib_avmm_cfg_regs.sv
// Directed bench for aib_avmm_cfg_regs: host-side AVMM driver, register
// model of all channels and a read-data scoreboard.
module tb_aib_avmm_cfg_regs;

  localparam int unsigned CHNL = 24;
  localparam int unsigned BW   = 32 * CHNL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [16:0]   addr = '0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [3:0]    byte_en = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          rdatavld;
  logic          waitreq;
  logic [BW-1:0] rx_cfg, tx_cfg, csr0, csr1;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mreg [CHNL][4];

  always #5 clk = ~clk;

  aib_avmm_cfg_regs #(.CHNL_NUM(CHNL), .CHNL_ID_LSB(11)) dut (
    .i_cfg_avmm_clk      (clk),
    .i_cfg_avmm_rst_n    (rst_n),
    .i_cfg_avmm_addr     (addr),
    .i_cfg_avmm_write    (write),
    .i_cfg_avmm_read     (read),
    .i_cfg_avmm_byte_en  (byte_en),
    .i_cfg_avmm_wdata    (wdata),
    .o_cfg_avmm_rdata    (rdata),
    .o_cfg_avmm_rdatavld (rdatavld),
    .o_cfg_avmm_waitreq  (waitreq),
    .o_rx_adapt_cfg      (rx_cfg),
    .o_tx_adapt_cfg      (tx_cfg),
    .o_aib_csr0          (csr0),
    .o_aib_csr1          (csr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int reg_sel(input logic [10:0] off);
    case (off)
      11'h208: return 0;
      11'h210: return 1;
      11'h218: return 2;
      11'h21C: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [16:0] a);
    int idx;
    int s;
    idx = int'(a[16:11]);
    s   = reg_sel(a[10:0]);
    if (idx >= int'(CHNL)) return 32'h0;
    if (a[10:0] == 11'h200) return 32'(idx);
    if (s < 0) return 32'h0;
    return mreg[idx][s];
  endfunction

  task automatic model_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be);
    int idx;
    int s;
    idx = int'(a[16:11]);
    s   = reg_sel(a[10:0]);
    if (idx < int'(CHNL) && s >= 0) begin
      for (int k = 0; k < 4; k++) if (be[k]) mreg[idx][s][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < int'(CHNL); n++)
      for (int s = 0; s < 4; s++) mreg[n][s] = 32'h0;
  endtask

  function automatic logic [BW-1:0] flat(input int s);
    logic [BW-1:0] r;
    for (int n = 0; n < int'(CHNL); n++) r[32*n +: 32] = mreg[n][s];
    return r;
  endfunction

  task automatic chk_all(input string tag);
    chk_bus({tag, "_rx"},   rx_cfg, flat(0));
    chk_bus({tag, "_tx"},   tx_cfg, flat(1));
    chk_bus({tag, "_csr0"}, csr0,   flat(2));
    chk_bus({tag, "_csr1"}, csr1,   flat(3));
  endtask

  // One host transaction: hold the request until waitreq drops, then release.
  task automatic do_req(input logic wr, input logic rd, input logic [16:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    int n;
    @(negedge clk);
    write = wr; read = rd; addr = a; wdata = d; byte_en = be;
    if (wr) model_write(a, d, be);
    else if (rd) exp_q.push_back(model_read(a));
    chk("waitreq_idle", 32'(waitreq), 32'd1);
    n = 0;
    while (waitreq !== 1'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("accept_latency", 32'(n), 32'd1);
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    chk("rdatavld_timing", 32'(rdatavld), 32'(rd && !wr));
  endtask

  // Read-data scoreboard and idle-zero check on rdata.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdatavld === 1'b1) begin
        chk("rdatavld_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("rdata", rdata, exp_q.pop_front());
      end else begin
        chk("rdata_idle_zero", rdata, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_waitreq", 32'(waitreq), 32'd1);
    chk("rst_rdatavld", 32'(rdatavld), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk_all("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_waitreq", 32'(waitreq), 32'd1);

    do_req(1'b0, 1'b1, 17'h00208, 32'h0, 4'h0);

    do_req(1'b1, 1'b0, 17'h01A10, 32'hDEAD_BEEF, 4'hF);
    chk("ch3_tx", tx_cfg[127:96], 32'hDEAD_BEEF);
    chk_all("ch3_wr");
    do_req(1'b0, 1'b1, 17'h01A10, 32'h0, 4'h0);

    do_req(1'b1, 1'b0, 17'h02A18, 32'hFFFF_FFFF, 4'hF);
    do_req(1'b1, 1'b0, 17'h02A18, 32'h1234_5678, 4'h5);
    chk("ch5_csr0_be", csr0[191:160], 32'hFF34_FF78);
    do_req(1'b1, 1'b0, 17'h02A18, 32'h0000_0000, 4'h0);
    chk("ch5_csr0_be0", csr0[191:160], 32'hFF34_FF78);
    chk_all("ch5_wr");
    do_req(1'b0, 1'b1, 17'h02A18, 32'h0, 4'h0);

    do_req(1'b0, 1'b1, 17'h0BA00, 32'h0, 4'h0);
    do_req(1'b1, 1'b0, 17'h0BA00, 32'hFFFF_FFFF, 4'hF);
    chk_all("ch23_id_wr");
    do_req(1'b0, 1'b1, 17'h0BA00, 32'h0, 4'h0);

    do_req(1'b1, 1'b0, 17'h0C208, 32'hCAFE_F00D, 4'hF);
    chk_all("ch24_wr");
    do_req(1'b0, 1'b1, 17'h0C208, 32'h0, 4'h0);

    do_req(1'b1, 1'b0, 17'h01204, 32'h1111_2222, 4'hF);
    chk_all("unmapped_wr");
    do_req(1'b0, 1'b1, 17'h01204, 32'h0, 4'h0);

    do_req(1'b1, 1'b1, 17'h00A1C, 32'hA5A5_A5A5, 4'hF);
    chk("ch1_csr1_rw", csr1[63:32], 32'hA5A5_A5A5);
    chk_all("ch1_rw");

    // Reset pulled during the accept cycle of a write.
    @(negedge clk);
    write = 1'b1; addr = 17'h00A1C; wdata = 32'h5A5A_5A5A; byte_en = 4'hF;
    n = 0;
    while (waitreq !== 1'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("abort_accept_latency", 32'(n), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    write = 1'b0;
    chk("abort_waitreq", 32'(waitreq), 32'd1);
    chk("abort_rdatavld", 32'(rdatavld), 32'd0);
    chk("abort_csr1", csr1[63:32], 32'h0);
    model_clear();
    chk_all("abort");
    rst_n = 1'b1;
    do_req(1'b0, 1'b1, 17'h00A1C, 32'h0, 4'h0);
    do_req(1'b0, 1'b1, 17'h01A10, 32'h0, 4'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aib_avmm_cfg_regs.md
Name: aib_avmm_cfg_regs

Overview:
- AVMM configuration register slave for the AIB PHY model, covering CHNL_NUM channels.
- Decodes the 17-bit AVMM address into a channel index and a register offset.
- Holds four 32-bit configuration registers per channel and drives them as flattened buses to the adapter and AIB I/O logic.
- Sits behind the model's AVMM port (i_cfg_avmm_*), one instance per die (master or slave).

Parameters:
- CHNL_NUM, 24: number of channels decoded; legal values 1..32.
- CHNL_ID_LSB, 11: lowest address bit of the channel-index field.

Ports:
- i_cfg_avmm_clk  in  1  configuration clock; all logic is rising-edge.
- i_cfg_avmm_rst_n  in  1  reset; asynchronous assert, active-low.
- i_cfg_avmm_addr  in  17  byte address; [16:CHNL_ID_LSB] is the channel index, [CHNL_ID_LSB-1:0] is the offset.
- i_cfg_avmm_write  in  1  write request.
- i_cfg_avmm_read  in  1  read request.
- i_cfg_avmm_byte_en  in  4  write byte enables.
- i_cfg_avmm_wdata  in  32  write data.
- o_cfg_avmm_rdata  out  32  read data.
- o_cfg_avmm_rdatavld  out  1  read-data-valid pulse.
- o_cfg_avmm_waitreq  out  1  Avalon waitrequest.
- o_rx_adapt_cfg  out  32*CHNL_NUM  per-channel offset 0x208; channel n occupies [32n+31:32n].
- o_tx_adapt_cfg  out  32*CHNL_NUM  per-channel offset 0x210.
- o_aib_csr0  out  32*CHNL_NUM  per-channel offset 0x218.
- o_aib_csr1  out  32*CHNL_NUM  per-channel offset 0x21C.

Behaviour:
- Reset values while i_cfg_avmm_rst_n=0:
  - all config registers 0x0000_0000
  - rdata 0
  - rdatavld 0
  - waitreq 1
  - FSM in IDLE
- FSM states:
  - IDLE: waitreq=1. If read or write is seen, go to ACCEPT and latch addr/wdata/byte_en/op.
  - ACCEPT: waitreq=0 for exactly one cycle. A write commits on this edge. A read captures rdata on this edge. Then go to RESP for a read, or IDLE for a write.
  - RESP: rdatavld=1 for exactly one cycle with rdata valid, then go to IDLE.
- Latency:
  - Write: request seen in cycle N, waitreq low in N+1, register updated at the end of N+1.
  - Read: rdatavld in cycle N+2. Minimum spacing is 2 cycles per write and 3 per read.
- Host contract: requests stay stable while waitreq=1 (Avalon rule). The slave samples only its latched copy.
- Simultaneous read and write: write wins; no rdatavld is produced.
- Write byte enables: byte k of the target register updates only if byte_en[k]=1. byte_en=0 means no change.
- Reads always return the full 32-bit word.
- Per-channel address map:
  - 0x200: read-only channel ID = {26'b0, channel index[5:0]}.
  - 0x208, 0x210, 0x218, 0x21C: read/write.
  - Any other offset: writes ignored, reads return 0.
- Channel index >= CHNL_NUM: writes ignored, reads return 0; the handshake still completes normally.
- o_cfg_avmm_rdata is 0 in every cycle except RESP.
- Reset asserted mid-transaction: aborts immediately to reset values; no rdatavld and no partial write.
- Config outputs come directly from the registers, so a new value is visible the cycle after the commit edge.

Decomposition:
- Package aib_cfg_pkg holds:
  - offset constants CFG_CHNL_ID=0x200, CFG_RX_ADAPT=0x208, CFG_TX_ADAPT=0x210, CFG_AIB_CSR0=0x218, CFG_AIB_CSR1=0x21C
  - FSM state enum {IDLE, ACCEPT, RESP}
  - function be_merge(old, wdata, be)
- One sub-module, aib_cfg_chnl_regs: the four registers for a single channel plus its read mux. It is instantiated CHNL_NUM times in a generate loop. The top level holds the FSM and the channel decode.

Test Plan:
- Reset then read ch0 offset 0x208 -> rdatavld after 2 cycles, rdata=0x0000_0000. While idle, waitreq=1.
- Write ch3 0x210 = 0xDEAD_BEEF with be=0xF -> o_tx_adapt_cfg[127:96]=0xDEADBEEF. All other channels remain 0. Read-back returns 0xDEADBEEF.
- Write ch5 0x218 = 0xFFFF_FFFF with be=0xF, then 0x1234_5678 with be=0x5 -> register holds 0xFF34_FF78.
- Read ch23 0x200 -> 0x0000_0017. Write 0xFFFF_FFFF to the same address -> read-back still 0x17.
- Write ch24 (addr 0x0C208, with CHNL_NUM=24) -> no output changes; read returns 0 with a normal handshake.
- Assert read and write together to ch1 0x21C with wdata 0xA5A5_A5A5 -> register updates, no rdatavld. Pulling reset during the ACCEPT cycle of a later write leaves 0 in the register.
